// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the control unit (master) and the
// iterative multiply/divide engine (slave).
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    // Handshake: Start is taken only while Busy=0, together with Op/A/B in
    // that same cycle. Busy stays high until the engine returns to idle.
    // Done pulses for one cycle, and Hi_out/Lo_out/Div_by_zero are valid
    // from that cycle on. Start is neither queued nor seen while Busy=1.
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi_out;
    logic [WIDTH-1:0] Lo_out;
    logic             Div_by_zero;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Hi_out, Lo_out, Div_by_zero
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, Hi_out, Lo_out, Div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) engine
// for MUL/DIV. Each takes one step per clock. Results land in Hi_out/Lo_out.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    muldiv_sequencer_if.slave    bus,
    output logic [2:0]           o_dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL_RUN = 3'd1,
        S_DIV_RUN = 3'd2,
        S_DIV_FIX = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_dbz;

    // Booth accumulator: {upper (WIDTH+1), multiplier (WIDTH), q-1}.
    // The upper half carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow.
    logic [2*WIDTH+1:0]  r_acc;
    logic [WIDTH:0]      w_upper;
    logic [WIDTH:0]      w_mext;
    logic [2*WIDTH+1:0]  w_acc_next;

    // Non-restoring divider on magnitudes.
    logic [WIDTH:0]      r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_dmag;
    logic [WIDTH:0]      w_dext;
    logic [WIDTH:0]      w_rem_sh;
    logic [WIDTH:0]      w_rem_next;
    logic [WIDTH-1:0]    w_quo_next;
    logic [WIDTH-1:0]    w_rem_fix;
    logic [WIDTH-1:0]    w_q_signed;
    logic [WIDTH-1:0]    w_r_signed;

    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_last;

    assign w_a_mag = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign w_b_mag = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
    assign w_last  = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_mext  = {r_a[WIDTH-1], r_a};
        w_upper = r_acc[2*WIDTH+1:WIDTH+1];
        case (r_acc[1:0])
            2'b01:   w_upper = w_upper + w_mext;
            2'b10:   w_upper = w_upper - w_mext;
            default: w_upper = r_acc[2*WIDTH+1:WIDTH+1];
        endcase
        w_acc_next = {w_upper[WIDTH], w_upper, r_acc[WIDTH:1]};
    end

    always_comb begin
        w_dext     = {1'b0, r_dmag};
        w_rem_sh   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_rem_next = r_rem[WIDTH] ? (w_rem_sh + w_dext) : (w_rem_sh - w_dext);
        w_quo_next = {r_quo[WIDTH-2:0], ~w_rem_next[WIDTH]};
        // The final correction leaves the remainder in [0, |B|), so WIDTH bits suffice.
        w_rem_fix  = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dmag) : r_rem[WIDTH-1:0];
        w_q_signed = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~r_quo + 1'b1) : r_quo;
        w_r_signed = r_a[WIDTH-1] ? (~w_rem_fix + 1'b1) : w_rem_fix;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A zero divisor skips the iterations and takes the one-cycle fixup
    // path, so its result is ready one cycle after Start.
    always_comb begin
        w_next_state = r_state;
        bus.Busy     = (r_state != S_IDLE);
        bus.Done     = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (!bus.Op)               w_next_state = S_MUL_RUN;
                    else if (bus.B == '0)      w_next_state = S_DIV_FIX;
                    else                       w_next_state = S_DIV_RUN;
                end
            end
            S_MUL_RUN: if (w_last) w_next_state = S_DONE;
            S_DIV_RUN: if (w_last) w_next_state = S_DIV_FIX;
            S_DIV_FIX: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dmag  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_count <= '0;
                        r_acc   <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dmag  <= w_b_mag;
                    end
                end
                S_MUL_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= w_last ? '0 : r_count + 1'b1;
                    if (w_last) begin
                        r_hi  <= w_acc_next[2*WIDTH:WIDTH+1];
                        r_lo  <= w_acc_next[WIDTH:1];
                        r_dbz <= 1'b0;
                    end
                end
                S_DIV_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= w_last ? '0 : r_count + 1'b1;
                end
                S_DIV_FIX: begin
                    if (r_b == '0) begin
                        r_hi  <= r_a;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi  <= w_r_signed;
                        r_lo  <= w_q_signed;
                        r_dbz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Hi_out      = r_hi;
    assign bus.Lo_out      = r_lo;
    assign bus.Div_by_zero = r_dbz;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, reset abort, and
// random operations against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] dbg_state;
    int         total = 0;
    int         bad   = 0;
    logic [W-1:0] exp_q[$];

    muldiv_sequencer_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dbz);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        if (!op) begin
            p  = sa * sb;
            u  = p;
            hi = u[63:32];
            lo = u[31:0];
        end else if (b == '0) begin
            hi  = a;
            lo  = '1;
            dbz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            u  = q;
            lo = u[31:0];
            u  = r;
            hi = u[31:0];
        end
    endfunction

    // Launch one operation, scramble inputs and re-pulse Start while busy,
    // then check latency, busy length, results and the single Done pulse.
    task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        int   lat;
        int   busy_n;
        int   exp_lat;
        logic seen;
        logic [W-1:0] e;
        exp_lat = !op ? W : ((b == '0) ? 1 : W + 1);
        exp_q.push_back(ehi);
        exp_q.push_back(elo);
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clock);
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && lat <= W + 10) begin
            @(negedge Clock);
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                seen = 1'b1;
            end else begin
                bus.Start = 1'($urandom_range(0, 1));
                bus.Op    = 1'($urandom_range(0, 1));
                bus.A     = $urandom;
                bus.B     = $urandom;
                @(posedge Clock);
                lat++;
            end
        end
        bus.Start = 1'b0;
        check({name, " done_seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_lat + 1));
        e = exp_q.pop_front();
        check({name, " hi"}, 64'(bus.Hi_out), 64'(e));
        e = exp_q.pop_front();
        check({name, " lo"}, 64'(bus.Lo_out), 64'(e));
        check({name, " dbz"}, 64'(bus.Div_by_zero), 64'(edbz));
        @(negedge Clock);
        check({name, " done_one_cycle"}, 64'({bus.Done, bus.Busy}), 64'd0);
    endtask

    initial begin
        logic [W-1:0] mhi, mlo;
        logic         mdbz;
        logic         rop;
        logic [W-1:0] ra, rb;
        int           dones;
        logic [W-1:0] corner[5];

        tbl[0] = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[2] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{1'b1, 32'h12345678,  32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[6] = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
        tbl[7] = '{1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        tbl[8] = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        tbl[9] = '{1'b1, 32'd5,         32'h80000000, 32'h00000005, 32'h00000000, 1'b0};
        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

        // Clock/reset
        bus.Start = 1'b0;
        bus.Op    = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        Reset     = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset outputs", {bus.Busy, bus.Done, bus.Div_by_zero},  64'd0);
        check("reset hi", 64'(bus.Hi_out), 64'd0);
        check("reset lo", 64'(bus.Lo_out), 64'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("idle no busy", 64'({bus.Busy, bus.Done}), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].dbz);
        end

        // Abort a multiply with Reset mid-operation.
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Op    = 1'b0;
        bus.A     = 32'd12345;
        bus.B     = 32'd678;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clock);
        check("abort busy before reset", 64'(bus.Busy), 64'd1);
        Reset = 1'b1;
        #1;
        check("abort busy", 64'(bus.Busy), 64'd0);
        check("abort hi", 64'(bus.Hi_out), 64'd0);
        check("abort lo", 64'(bus.Lo_out), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge Clock);
            if (bus.Done || bus.Busy) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        run_op("after_abort", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = corner[$urandom_range(0, 4)];
                2:       rb = W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, mhi, mlo, mdbz);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, mhi, mlo, mdbz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
